score_display: RTL and testbench
================================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit stays enabled during scanning.
REQ-002 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port score  input  32  running score from the score calculator, interpreted as two's complement.
REQ-005 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a} of the enabled digit, active-low.
REQ-006 SHALL have port an  output  8  digit enables, active-low; bit 0 is the rightmost digit.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-008 SHALL keep a registered copy of the last converted score (last_score) and an FSM with states IDLE, SHIFT, DONE.
REQ-009 In IDLE, when score != last_score, SHALL capture score and last_score, load the magnitude and sign, clear the BCD accumulator, and go to SHIFT.
REQ-010 Magnitude SHALL be score if bit 31 = 0, else the 32-bit two's complement negation; negative SHALL be bit 31.
REQ-011 SHIFT SHALL run exactly 32 cycles of double-dabble (add 3 to any BCD nibble >= 5, then shift left one bit) over a 40-bit BCD accumulator, then go to DONE.
REQ-012 DONE SHALL last one cycle, write the display digit registers, and return to IDLE.
REQ-013 Display digits SHALL change on the 34th rising edge after the capture edge, with no intermediate values shown.
REQ-014 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-015 Changes on score while busy SHALL be ignored; the value present on return to IDLE SHALL be compared and converted (latest value wins).
REQ-016 Non-negative magnitude > 99999999 SHALL display 99999999.
REQ-017 Negative magnitude > 9999999 SHALL display -9999999.
REQ-018 Negative values SHALL place a minus sign (segment g only) immediately left of the most significant shown digit.
REQ-019 A free-running refresh counter SHALL advance the scanned digit index 0..7 every REFRESH_DIV cycles, wrapping 7->0.
REQ-020 Exactly one an bit SHALL be low at any time outside reset.
REQ-021 seg SHALL be the decoded glyph for the scanned digit (0-9, minus, or blank = all ones); seg and an SHALL be registered.
REQ-022 Value 0 SHALL display a single 0 in digit 0.

Reset
REQ-023 On resetn low, asynchronously: state IDLE, last_score 0, digits all 0, sign 0, refresh counter 0, index 0, busy 0, an = 8'b11111110, seg = glyph 0.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the conversion; after release, a nonzero score SHALL be captured on the first IDLE edge.

Configuration
REQ-025 Macro SCORE_DISPLAY_BLANK_EN, when defined, SHALL blank leading zeros left of the most significant nonzero digit (digit 0 is never blank).
REQ-026 Without SCORE_DISPLAY_BLANK_EN, leading zeros SHALL be shown and the minus sign SHALL occupy digit 7.
REQ-027 Without SCORE_DISPLAY_BLANK_EN, negative saturation SHALL still be -9999999.

Verification
REQ-028 score 0 -> 300 (REFRESH_DIV=4) -> busy high 33 cycles; digits 00000300, or "     300" with blanking.
REQ-029 score 32'hFFFFFF9C (-100) -> "-00000100" is invalid; required "0000-100" style is not allowed. Required with blanking: "    -100"; without: "-0000100".
REQ-030 score 123456789 -> displays 99999999; score 32'h80000000 -> displays -9999999.
REQ-031 score 300 then 600 at cycle 5 of SHIFT, then 900 at cycle 10 -> 300 shown, then exactly one more conversion, ending at 900.
REQ-032 resetn pulsed low at SHIFT cycle 16 with score=500 -> all outputs at reset values immediately; 500 shown 34 edges after release.
REQ-033 Steady state, REFRESH_DIV=4 -> an walks FE,FD,FB,...,7F,FE, 4 cycles each, exactly one bit low throughout.

Source files
------------

// File: rtl/score_display.sv
// Signed 32-bit score to 8-digit multiplexed seven-segment display via double-dabble.
// Optional SCORE_DISPLAY_BLANK_EN blanks leading zeros and floats the minus sign.
module score_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] score,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] RMAX = CW'(REFRESH_DIV - 1);

    localparam logic [3:0] C_MINUS = 4'd10;
    localparam logic [3:0] C_BLANK = 4'd15;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      last_score;
    logic [31:0]      mag;
    logic             neg;
    logic [39:0]      bcd;
    logic [39:0]      bcd_adj;
    logic [4:0]       cnt;
    logic [7:0][3:0]  digits;
    logic             sign;
    logic             sat_pos;
    logic             sat_neg;
    logic [CW-1:0]    rcnt;
    logic [2:0]       idx;
    logic [3:0]       code;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            C_MINUS: g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (score != last_score) state_nxt = SHIFT;
            SHIFT:   if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Clamp to what fits: 8 digits positive, 7 digits plus sign negative.
    assign sat_pos = !neg && (bcd[39:32] != 8'd0);
    assign sat_neg = neg && (bcd[39:28] != 12'd0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_score <= '0;
            mag        <= '0;
            neg        <= 1'b0;
            bcd        <= '0;
            cnt        <= '0;
            digits     <= '0;
            sign       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (score != last_score) begin
                        last_score <= score;
                        mag        <= score[31] ? (~score + 32'd1) : score;
                        neg        <= score[31];
                        bcd        <= '0;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[38:0], mag[31]};
                    mag <= {mag[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                DONE: begin
                    sign <= neg;
                    for (int i = 0; i < 8; i++) begin
                        if (sat_pos || (sat_neg && i < 7)) digits[i] <= 4'd9;
                        else if (neg && i == 7)            digits[i] <= 4'd0;
                        else                               digits[i] <= bcd[4*i +: 4];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == RMAX) begin
            rcnt <= '0;
            idx  <= idx + 3'd1;
        end else begin
            rcnt <= rcnt + CW'(1);
        end
    end

`ifdef SCORE_DISPLAY_BLANK_EN
    logic [2:0] msd;

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (digits[i] != 4'd0) msd = 3'(i);
        end
    end

    // Minus sits just left of the most significant shown digit.
    always_comb begin
        code = digits[idx];
        if (idx > msd) begin
            if (sign && idx == msd + 3'd1) code = C_MINUS;
            else                           code = C_BLANK;
        end
    end
`else
    always_comb begin
        code = digits[idx];
        if (sign && idx == 3'd7) code = C_MINUS;
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            an  <= 8'hFE;
            seg <= 7'h40;
        end else begin
            an  <= ~(8'd1 << idx);
            seg <= glyph(code);
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Randomised self-checking bench for score_display against an arithmetic display model.
// Honors SCORE_DISPLAY_BLANK_EN in the model when the design is built with it.
module tb_score_display;

    logic        clock;
    logic        resetn;
    logic [31:0] score;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        busy;

    int total;
    int bad;

    score_display #(.REFRESH_DIV(4)) dut (
        .clock (clock),
        .resetn(resetn),
        .score (score),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            10:      return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected seg per digit position, position p at bits [p*7 +: 7].
    function automatic logic [55:0] model_disp(input logic [31:0] s);
        logic [55:0] r;
        longint m;
        longint t;
        longint p10;
        bit n;
        int nd;
        int c;
        n = s[31];
        m = longint'({32'd0, s});
        if (n) m = 64'h1_0000_0000 - m;
        if (!n && m > 99999999) m = 99999999;
        if (n && m > 9999999) m = 9999999;
        nd = 1;
        t = m / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        p10 = 1;
        for (int p = 0; p < 8; p++) begin
            c = int'((m / p10) % 10);
`ifdef SCORE_DISPLAY_BLANK_EN
            if (p >= nd) c = (n && p == nd) ? 10 : 11;
`else
            if (n && p == 7) c = 10;
`endif
            r[p*7 +: 7] = glyph(c);
            p10 = p10 * 10;
        end
        return r;
    endfunction

    task automatic collect(input int n, output logic [55:0] v, output int oh_bad);
        v = '1;
        oh_bad = 0;
        repeat (n) begin
            @(negedge clock);
            if ($countones(~an) != 1) oh_bad++;
            else for (int p = 0; p < 8; p++) if (!an[p]) v[p*7 +: 7] = seg;
        end
    endtask

    task automatic wait_busy(input logic lvl, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (busy === lvl) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Waits for busy to rise, then counts busy cycles while checking seg stays at old.
    task automatic measure_busy(input logic [55:0] old, output int n, output int viol);
        bit ok;
        n = 0;
        viol = 0;
        wait_busy(1'b1, 4, ok);
        while (ok && busy === 1'b1 && n < 60) begin
            n++;
            for (int p = 0; p < 8; p++)
                if (!an[p] && seg !== old[p*7 +: 7]) viol++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        score = 32'd0;
        repeat (3) @(negedge clock);
        total++;
        if ({an, seg, busy} !== {8'hFE, 7'h40, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold an=%h seg=%h busy=%b want an=fe seg=40 busy=0",
                     an, seg, busy);
        end
        resetn = 1'b1;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || an !== 8'hFE) begin
            bad++;
            $display("FAIL reset_release an=%h busy=%b want an=fe busy=0", an, busy);
        end
    endtask

    task automatic test_300;
        int n;
        int viol;
        int oh;
        logic [55:0] v;
        score = 32'd300;
        measure_busy(model_disp(32'd0), n, viol);
        total++;
        if (n != 33) begin
            bad++;
            $display("FAIL busy_len got=%0d want=33", n);
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL no_intermediate got=%0d changes want=0", viol);
        end
        repeat (2) @(negedge clock);
        collect(32, v, oh);
        total++;
        if (v !== model_disp(32'd300) || oh != 0) begin
            bad++;
            $display("FAIL show_300 got=%h want=%h onehot_bad=%0d",
                     v, model_disp(32'd300), oh);
        end
    endtask

    task automatic convert_check(input string name, input logic [31:0] s);
        bit ok;
        int oh;
        logic [55:0] v;
        score = s;
        wait_busy(1'b1, 4, ok);
        if (ok) wait_busy(1'b0, 40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout score=%h busy=%b want conversion", name, s, busy);
        end
        repeat (2) @(negedge clock);
        collect(32, v, oh);
        total++;
        if (v !== model_disp(s) || oh != 0) begin
            bad++;
            $display("FAIL %s score=%h got=%h want=%h onehot_bad=%0d",
                     name, s, v, model_disp(s), oh);
        end
    endtask

    task automatic test_saturate;
        convert_check("neg100", 32'hFFFFFF9C);
        convert_check("sat_pos", 32'd123456789);
        convert_check("sat_neg", 32'h80000000);
    endtask

    task automatic test_latest_wins;
        bit ok;
        int oh;
        logic [55:0] v;
        score = 32'd300;
        wait_busy(1'b1, 4, ok);
        repeat (5) @(negedge clock);
        score = 32'd600;
        repeat (5) @(negedge clock);
        score = 32'd900;
        wait_busy(1'b0, 40, ok);
        if (ok) wait_busy(1'b1, 3, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL second_conv busy=%b want a second conversion", busy);
        end
        collect(32, v, oh);
        total++;
        if (v !== model_disp(32'd300)) begin
            bad++;
            $display("FAIL first_shown got=%h want=%h", v, model_disp(32'd300));
        end
        wait_busy(1'b0, 40, ok);
        repeat (2) @(negedge clock);
        collect(32, v, oh);
        total++;
        if (v !== model_disp(32'd900)) begin
            bad++;
            $display("FAIL final_900 got=%h want=%h", v, model_disp(32'd900));
        end
        wait_busy(1'b1, 40, ok);
        total++;
        if (ok) begin
            bad++;
            $display("FAIL extra_conv busy=%b want no third conversion", busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        int viol;
        int oh;
        logic [55:0] v;
        score = 32'd500;
        wait_busy(1'b1, 4, ok);
        repeat (15) @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        total++;
        if ({an, seg, busy} !== {8'hFE, 7'h40, 1'b0}) begin
            bad++;
            $display("FAIL async_reset an=%h seg=%h busy=%b want an=fe seg=40 busy=0",
                     an, seg, busy);
        end
        @(negedge clock);
        resetn = 1'b1;
        measure_busy(model_disp(32'd0), n, viol);
        total++;
        if (n != 33 || viol != 0) begin
            bad++;
            $display("FAIL restart busy_len=%0d changes=%0d want 33 and 0", n, viol);
        end
        repeat (2) @(negedge clock);
        collect(32, v, oh);
        total++;
        if (v !== model_disp(32'd500)) begin
            bad++;
            $display("FAIL show_500 got=%h want=%h", v, model_disp(32'd500));
        end
    endtask

    task automatic test_scan;
        logic [7:0] prev;
        int run;
        int first;
        int oh_bad;
        int seq_bad;
        int dwell_bad;
        oh_bad = 0;
        seq_bad = 0;
        dwell_bad = 0;
        first = 1;
        run = 0;
        @(negedge clock);
        prev = an;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            if ($countones(~an) != 1) oh_bad++;
            run++;
            if (an !== prev) begin
                if (an !== {prev[6:0], prev[7]}) seq_bad++;
                if (!first && run != 4) dwell_bad++;
                first = 0;
                run = 0;
                prev = an;
            end
        end
        total++;
        if (oh_bad != 0) begin
            bad++;
            $display("FAIL scan_onehot got=%0d bad samples want=0", oh_bad);
        end
        total++;
        if (seq_bad != 0 || first) begin
            bad++;
            $display("FAIL scan_order got=%0d bad steps want=0", seq_bad);
        end
        total++;
        if (dwell_bad != 0) begin
            bad++;
            $display("FAIL scan_dwell got=%0d bad runs want=0", dwell_bad);
        end
    endtask

    task automatic test_random;
        logic [31:0] s;
        logic [31:0] prev;
        logic [31:0] fixed [8];
        fixed[0] = 32'd99999999;
        fixed[1] = 32'd100000000;
        fixed[2] = 32'hFF676981;
        fixed[3] = 32'hFF676980;
        fixed[4] = 32'd0;
        fixed[5] = 32'd1;
        fixed[6] = 32'hFFFFFFFF;
        fixed[7] = 32'h7FFFFFFF;
        prev = score;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) s = fixed[i];
            else case (i % 3)
                0:       s = $urandom;
                1:       s = $urandom_range(0, 99999999);
                default: s = 32'd0 - 32'($urandom_range(1, 9999999));
            endcase
            if (s == prev) s = s ^ 32'd1;
            convert_check("rand", s);
            prev = s;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_300();
        test_saturate();
        test_latest_wins();
        test_reset_mid();
        test_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
